// File: rtl/accelbrot_loop_exit.sv
// Loop exit stage: recirculates unfinished pixel packets and retires finished ones as {tag, count}
// through a first-word-fall-through result FIFO. Optional counters: ACCELBROT_LOOP_EXIT_STATS_EN.
module accelbrot_loop_exit #(
    parameter int unsigned NWORDS      = 8,
    parameter int unsigned WWIDTH      = 34,
    parameter int unsigned CWIDTH      = 16,
    parameter int unsigned TWIDTH      = 24,
    parameter int unsigned RFIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CWIDTH-1:0] cfg_max_iter_i,
    input  logic [WWIDTH-1:0] in_x_i,
    input  logic [WWIDTH-1:0] in_y_i,
    input  logic [WWIDTH-1:0] in_a_i,
    input  logic [WWIDTH-1:0] in_b_i,
    input  logic [TWIDTH-1:0] in_tag_i,
    input  logic [CWIDTH-1:0] in_count_i,
    input  logic              in_finish_i,
    input  logic              in_start_i,
    input  logic              in_valid_i,
    output logic [WWIDTH-1:0] cont_x_o,
    output logic [WWIDTH-1:0] cont_y_o,
    output logic [WWIDTH-1:0] cont_a_o,
    output logic [WWIDTH-1:0] cont_b_o,
    output logic [TWIDTH-1:0] cont_tag_o,
    output logic [CWIDTH-1:0] cont_count_o,
    output logic              cont_finish_o,
    output logic              cont_start_o,
    output logic              cont_valid_o,
    output logic [TWIDTH-1:0] res_tag_o,
    output logic [CWIDTH-1:0] res_count_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [31:0]       sts_num_exited_o,
    output logic [31:0]       sts_num_retried_o
);

    localparam int unsigned CntW = $clog2(NWORDS);
    localparam int unsigned PtrW = $clog2(RFIFO_DEPTH);
    localparam int unsigned EntW = TWIDTH + CWIDTH;

    typedef enum logic [1:0] {StIdle, StFwd, StDrop, StSkip} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wcnt_q, wcnt_d;

    logic [EntW-1:0] mem_q [RFIFO_DEPTH];
    logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
    logic [EntW-1:0] rd_ent;
    logic            fifo_full, fifo_empty, push, pop;

    logic start_w, done, fwd_word;

    logic [WWIDTH-1:0] cont_x_q, cont_x_d, cont_y_q, cont_y_d;
    logic [WWIDTH-1:0] cont_a_q, cont_a_d, cont_b_q, cont_b_d;
    logic [TWIDTH-1:0] cont_tag_q, cont_tag_d;
    logic [CWIDTH-1:0] cont_count_q, cont_count_d;
    logic              cont_finish_q, cont_finish_d;
    logic              cont_start_q, cont_start_d;
    logic              cont_valid_q, cont_valid_d;

    // Full is judged on the occupancy before this cycle's pop.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

    assign start_w = in_valid_i & in_start_i;
    assign done    = in_finish_i | (in_count_i >= cfg_max_iter_i);
    assign push    = start_w & done & ~fifo_full;
    assign pop     = ~fifo_empty & res_ready_i;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        fwd_word = 1'b0;
        if (start_w) begin
            wcnt_d   = CntW'(1);
            state_d  = push ? StDrop : StFwd;
            fwd_word = ~push;
        end else if (in_valid_i) begin
            case (state_q)
                StIdle: state_d = StSkip;
                StSkip: state_d = StSkip;
                default: begin
                    fwd_word = (state_q == StFwd);
                    if (wcnt_q == CntW'(NWORDS - 1)) begin
                        state_d = StIdle;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        cont_valid_d  = fwd_word;
        cont_start_d  = fwd_word & start_w;
        cont_x_d      = fwd_word ? in_x_i : cont_x_q;
        cont_y_d      = fwd_word ? in_y_i : cont_y_q;
        cont_a_d      = fwd_word ? in_a_i : cont_a_q;
        cont_b_d      = fwd_word ? in_b_i : cont_b_q;
        cont_tag_d    = cont_tag_q;
        cont_count_d  = cont_count_q;
        cont_finish_d = cont_finish_q;
        // A finished packet reaching here could not be retired, so it goes round flagged done.
        if (start_w && !push) begin
            cont_tag_d    = in_tag_i;
            cont_count_d  = in_count_i;
            cont_finish_d = done;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            wcnt_q        <= '0;
            cont_x_q      <= '0;
            cont_y_q      <= '0;
            cont_a_q      <= '0;
            cont_b_q      <= '0;
            cont_tag_q    <= '0;
            cont_count_q  <= '0;
            cont_finish_q <= 1'b0;
            cont_start_q  <= 1'b0;
            cont_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            cont_x_q      <= cont_x_d;
            cont_y_q      <= cont_y_d;
            cont_a_q      <= cont_a_d;
            cont_b_q      <= cont_b_d;
            cont_tag_q    <= cont_tag_d;
            cont_count_q  <= cont_count_d;
            cont_finish_q <= cont_finish_d;
            cont_start_q  <= cont_start_d;
            cont_valid_q  <= cont_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= {in_tag_i, in_count_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Result fields read as zero while empty so reset clears every res_* output.
    assign rd_ent      = mem_q[rd_ptr_q[PtrW-1:0]];
    assign res_valid_o = ~fifo_empty;
    assign res_tag_o   = fifo_empty ? '0 : rd_ent[EntW-1:CWIDTH];
    assign res_count_o = fifo_empty ? '0 : rd_ent[CWIDTH-1:0];

    assign cont_x_o      = cont_x_q;
    assign cont_y_o      = cont_y_q;
    assign cont_a_o      = cont_a_q;
    assign cont_b_o      = cont_b_q;
    assign cont_tag_o    = cont_tag_q;
    assign cont_count_o  = cont_count_q;
    assign cont_finish_o = cont_finish_q;
    assign cont_start_o  = cont_start_q;
    assign cont_valid_o  = cont_valid_q;

`ifdef ACCELBROT_LOOP_EXIT_STATS_EN
    logic [31:0] exited_q, retried_q;
    logic        retry;

    assign retry = start_w & done & fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exited_q  <= '0;
            retried_q <= '0;
        end else begin
            if (push) begin
                exited_q <= exited_q + 32'd1;
            end
            if (retry) begin
                retried_q <= retried_q + 32'd1;
            end
        end
    end

    assign sts_num_exited_o  = exited_q;
    assign sts_num_retried_o = retried_q;
`else
    assign sts_num_exited_o  = '0;
    assign sts_num_retried_o = '0;
`endif

endmodule

// File: tb/tb_accelbrot_loop_exit.sv
// Self-checking bench for accelbrot_loop_exit: directed scenarios plus random traffic compared
// against a packet-level reference model (queue-based result FIFO).
module tb_accelbrot_loop_exit;

    localparam int NW = 8;
    localparam int WW = 34;
    localparam int CW = 16;
    localparam int TW = 24;
    localparam int DEPTH = 16;
    localparam int CF = 1 + TW + CW + 1 + 4 * WW;
    localparam int RF = TW + CW;
    localparam int OW = 1 + CF + 1 + RF + 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] cfg_max_iter_i;
    logic [WW-1:0] in_x_i, in_y_i, in_a_i, in_b_i;
    logic [TW-1:0] in_tag_i;
    logic [CW-1:0] in_count_i;
    logic          in_finish_i, in_start_i, in_valid_i;
    logic [WW-1:0] cont_x_o, cont_y_o, cont_a_o, cont_b_o;
    logic [TW-1:0] cont_tag_o;
    logic [CW-1:0] cont_count_o;
    logic          cont_finish_o, cont_start_o, cont_valid_o;
    logic [TW-1:0] res_tag_o;
    logic [CW-1:0] res_count_o;
    logic          res_valid_o, res_ready_i;
    logic [31:0]   sts_num_exited_o, sts_num_retried_o;

    always #5 clk = ~clk;

    accelbrot_loop_exit dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_max_iter_i   (cfg_max_iter_i),
        .in_x_i           (in_x_i),
        .in_y_i           (in_y_i),
        .in_a_i           (in_a_i),
        .in_b_i           (in_b_i),
        .in_tag_i         (in_tag_i),
        .in_count_i       (in_count_i),
        .in_finish_i      (in_finish_i),
        .in_start_i       (in_start_i),
        .in_valid_i       (in_valid_i),
        .cont_x_o         (cont_x_o),
        .cont_y_o         (cont_y_o),
        .cont_a_o         (cont_a_o),
        .cont_b_o         (cont_b_o),
        .cont_tag_o       (cont_tag_o),
        .cont_count_o     (cont_count_o),
        .cont_finish_o    (cont_finish_o),
        .cont_start_o     (cont_start_o),
        .cont_valid_o     (cont_valid_o),
        .res_tag_o        (res_tag_o),
        .res_count_o      (res_count_o),
        .res_valid_o      (res_valid_o),
        .res_ready_i      (res_ready_i),
        .sts_num_exited_o (sts_num_exited_o),
        .sts_num_retried_o(sts_num_retried_o)
    );

    typedef struct {
        bit          v;
        bit          s;
        bit          fin;
        bit [TW-1:0] tag;
        bit [CW-1:0] cnt;
        bit          rr;
    } stim_t;

    int errors = 0;
    int checks = 0;
    stim_t stim_q[$];

    // Reference model: packet position plus a queue standing in for the result FIFO.
    bit [RF-1:0]  m_fifo[$];
    bit           m_in_pkt, m_fwd;
    int           m_pos;
    bit           m_cv, m_cs, m_fin;
    bit [TW-1:0]  m_tag;
    bit [CW-1:0]  m_cnt;
    bit [WW-1:0]  m_x, m_y, m_a, m_b;
    int unsigned  m_exited, m_retried;

    task automatic model_reset();
        m_fifo.delete();
        m_in_pkt = 0; m_fwd = 0; m_pos = 0;
        m_cv = 0; m_cs = 0; m_fin = 0; m_tag = '0; m_cnt = '0;
        m_x = '0; m_y = '0; m_a = '0; m_b = '0;
        m_exited = 0; m_retried = 0;
    endtask

    task automatic model_edge();
        bit pop, full, done;
        pop  = (m_fifo.size() != 0) && res_ready_i;
        full = (m_fifo.size() == DEPTH);
        if (pop) void'(m_fifo.pop_front());
        m_cv = 0;
        m_cs = 0;
        if (in_valid_i && in_start_i) begin
            done = in_finish_i || (in_count_i >= cfg_max_iter_i);
            m_in_pkt = 1;
            m_pos = 1;
            if (done && !full) begin
                m_fifo.push_back({in_tag_i, in_count_i});
                m_exited++;
                m_fwd = 0;
            end else begin
                if (done) m_retried++;
                m_fwd = 1;
                m_cv = 1;
                m_cs = 1;
                m_tag = in_tag_i;
                m_cnt = in_count_i;
                m_fin = done;
            end
        end else if (in_valid_i && m_in_pkt) begin
            m_cv = m_fwd;
            m_pos++;
            if (m_pos == NW) m_in_pkt = 0;
        end
        if (m_cv) begin
            m_x = in_x_i; m_y = in_y_i; m_a = in_a_i; m_b = in_b_i;
        end
    endtask

    function automatic logic [OW-1:0] observed();
        logic [CF-1:0] c;
        logic [RF-1:0] r;
        c = {cont_start_o, cont_tag_o, cont_count_o, cont_finish_o,
             cont_x_o, cont_y_o, cont_a_o, cont_b_o} & {CF{cont_valid_o}};
        r = {res_tag_o, res_count_o} & {RF{res_valid_o}};
        return {cont_valid_o, c, res_valid_o, r, sts_num_exited_o, sts_num_retried_o};
    endfunction

    function automatic logic [OW-1:0] expected();
        logic [CF-1:0] c;
        logic [RF-1:0] r;
        logic [31:0]   ex, rt;
        c = {m_cs, m_tag, m_cnt, m_fin, m_x, m_y, m_a, m_b} & {CF{m_cv}};
        r = (m_fifo.size() != 0) ? m_fifo[0] : '0;
`ifdef ACCELBROT_LOOP_EXIT_STATS_EN
        ex = m_exited;
        rt = m_retried;
`else
        ex = '0;
        rt = '0;
`endif
        return {m_cv, c, m_fifo.size() != 0, r, ex, rt};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply(input stim_t st);
        in_valid_i  = st.v;
        in_start_i  = st.s;
        in_finish_i = st.fin;
        in_tag_i    = st.tag;
        in_count_i  = st.cnt;
        res_ready_i = st.rr;
        in_x_i = WW'({$urandom(), $urandom()});
        in_y_i = WW'({$urandom(), $urandom()});
        in_a_i = WW'({$urandom(), $urandom()});
        in_b_i = WW'({$urandom(), $urandom()});
        tick();
    endtask

    task automatic add_idle(input int n, input bit rr);
        stim_t st;
        for (int i = 0; i < n; i++) begin
            st = '{v: 0, s: 0, fin: 0, tag: '0, cnt: '0, rr: rr};
            stim_q.push_back(st);
        end
    endtask

    // nwords words of one packet, optionally with a gap of gap_len idle cycles after word gap_at.
    task automatic add_pkt(input bit [TW-1:0] tag, input bit [CW-1:0] cnt, input bit fin,
                           input bit rr, input int nwords, input int gap_at, input int gap_len);
        stim_t st;
        for (int i = 0; i < nwords; i++) begin
            st = '{v: 1, s: (i == 0), fin: fin, tag: tag, cnt: cnt, rr: rr};
            stim_q.push_back(st);
            if (i == gap_at) add_idle(gap_len, rr);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid_i = 0; in_start_i = 0; in_finish_i = 0; res_ready_i = 0;
        in_tag_i = '0; in_count_i = '0;
        in_x_i = '0; in_y_i = '0; in_a_i = '0; in_b_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        cfg_max_iter_i = 16'd100;
        do_reset();
        checks++;
        if ({cont_valid_o, cont_start_o, cont_finish_o, cont_tag_o, cont_count_o, cont_x_o,
             cont_y_o, cont_a_o, cont_b_o, res_valid_o, res_tag_o, res_count_o,
             sts_num_exited_o, sts_num_retried_o} !== '0) begin
            errors++;
            $display("FAIL reset_state got cv=%b rv=%b ex=%0d rt=%0d required all zero",
                     cont_valid_o, res_valid_o, sts_num_exited_o, sts_num_retried_o);
        end
    endtask

    task automatic test_forward();
        int n_cv = 0, n_cs = 0, bad_cnt = 0;
        stim_q.delete();
        add_pkt(24'h000123, 16'd5, 1'b0, 1'b1, NW, -1, 0);
        add_idle(3, 1'b1);
        foreach (stim_q[i]) begin
            apply(stim_q[i]);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL forward cyc=%0d got=%h exp=%h", i, observed(), expected());
            end
            if (cont_valid_o) begin
                n_cv++;
                if (cont_start_o) n_cs++;
                if (cont_count_o !== 16'd5 || res_valid_o) bad_cnt++;
            end
        end
        checks++;
        if (n_cv != NW || n_cs != 1 || bad_cnt != 0) begin
            errors++;
            $display("FAIL forward_shape got words=%0d starts=%0d bad=%0d required 8 1 0",
                     n_cv, n_cs, bad_cnt);
        end
    endtask

    task automatic test_retire();
        int n_cv = 0;
        stim_q.delete();
        add_pkt(24'h000123, 16'd100, 1'b0, 1'b1, NW, -1, 0);
        add_idle(2, 1'b1);
        foreach (stim_q[i]) begin
            apply(stim_q[i]);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL retire cyc=%0d got=%h exp=%h", i, observed(), expected());
            end
            if (cont_valid_o) n_cv++;
            if (i == 0) begin
                checks++;
                if (!res_valid_o || res_tag_o !== 24'h000123 || res_count_o !== 16'd100) begin
                    errors++;
                    $display("FAIL retire_result got v=%b tag=%h cnt=%0d required 1 000123 100",
                             res_valid_o, res_tag_o, res_count_o);
                end
            end
        end
        checks++;
        if (n_cv != 0) begin
            errors++;
            $display("FAIL retire_no_cont got %0d cont words required 0", n_cv);
        end
    endtask

    task automatic test_fifo_full();
        int retry_starts = 0;
        stim_q.delete();
        for (int k = 0; k < DEPTH + 1; k++) begin
            add_pkt(TW'(24'h000200 + k), CW'($urandom_range(0, 50)), 1'b1, 1'b0, NW, -1, 0);
        end
        add_idle(DEPTH + 4, 1'b1);
        foreach (stim_q[i]) begin
            apply(stim_q[i]);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL fifo_full cyc=%0d got=%h exp=%h", i, observed(), expected());
            end
            if (cont_valid_o && cont_start_o && cont_finish_o) begin
                retry_starts++;
                checks++;
                if (cont_tag_o !== 24'h000210) begin
                    errors++;
                    $display("FAIL fifo_full_retry_tag got %h required 000210", cont_tag_o);
                end
            end
        end
        checks++;
        if (retry_starts != 1 || res_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full_summary got retries=%0d res_valid=%b required 1 0",
                     retry_starts, res_valid_o);
        end
    endtask

    task automatic test_gaps();
        int n_cv = 0;
        stim_q.delete();
        add_pkt(24'h00ABCD, 16'd7, 1'b0, 1'b1, NW, 3, 2);
        add_idle(1, 1'b1);
        add_pkt(24'h00EEEE, 16'd7, 1'b0, 1'b1, 2, -1, 0);
        stim_q[$ - 1].s = 1'b0;
        stim_q[$].s = 1'b0;
        add_idle(2, 1'b1);
        foreach (stim_q[i]) begin
            apply(stim_q[i]);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL gaps cyc=%0d got=%h exp=%h", i, observed(), expected());
            end
            if (cont_valid_o) n_cv++;
        end
        checks++;
        if (n_cv != NW) begin
            errors++;
            $display("FAIL gaps_words got %0d cont words required 8", n_cv);
        end
    endtask

    task automatic test_restart();
        int n_cs = 0;
        stim_q.delete();
        add_pkt(24'h000AAA, 16'd3, 1'b0, 1'b1, 4, -1, 0);
        add_pkt(24'h000BBB, 16'd9, 1'b0, 1'b1, NW, -1, 0);
        add_idle(2, 1'b1);
        foreach (stim_q[i]) begin
            apply(stim_q[i]);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL restart cyc=%0d got=%h exp=%h", i, observed(), expected());
            end
            if (cont_valid_o && cont_start_o) n_cs++;
        end
        checks++;
        if (n_cs != 2 || cont_tag_o !== 24'h000BBB) begin
            errors++;
            $display("FAIL restart_starts got starts=%0d tag=%h required 2 000BBB", n_cs, cont_tag_o);
        end
    endtask

    task automatic test_reset_mid();
        int n_cv = 0;
        stim_q.delete();
        add_pkt(24'h000C0C, 16'd2, 1'b0, 1'b1, 5, -1, 0);
        foreach (stim_q[i]) begin
            apply(stim_q[i]);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", i, observed(), expected());
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cont_valid_o, cont_start_o, cont_finish_o, cont_tag_o, cont_count_o, cont_x_o,
             res_valid_o, res_tag_o, res_count_o, sts_num_exited_o, sts_num_retried_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async got cv=%b tag=%h required all zero",
                     cont_valid_o, cont_tag_o);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        stim_q.delete();
        add_pkt(24'h000C0C, 16'd2, 1'b0, 1'b1, 3, -1, 0);
        stim_q[0].s = 1'b0;
        add_idle(2, 1'b1);
        foreach (stim_q[i]) begin
            apply(stim_q[i]);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", i, observed(), expected());
            end
            if (cont_valid_o) n_cv++;
        end
        checks++;
        if (n_cv != 0) begin
            errors++;
            $display("FAIL reset_mid_drop got %0d cont words required 0", n_cv);
        end
    endtask

    task automatic test_random();
        stim_t st;
        int    rr_pct;
        bit [CW-1:0] cfgs[3];
        cfgs[0] = 16'd0;
        cfgs[1] = 16'd50;
        cfgs[2] = 16'hFFFF;
        rr_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 0) begin
                cfg_max_iter_i = cfgs[$urandom_range(0, 2)];
                rr_pct = $urandom_range(0, 3) * 30;
            end
            st.v   = ($urandom_range(0, 9) < 8);
            st.s   = ($urandom_range(0, 7) == 0);
            st.fin = ($urandom_range(0, 3) == 0);
            st.tag = TW'($urandom());
            st.cnt = CW'($urandom_range(0, 120));
            st.rr  = ($urandom_range(0, 99) < rr_pct);
            apply(st);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, observed(), expected());
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_forward();
        test_retire();
        test_fifo_full();
        test_gaps();
        test_restart();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
